// File: rtl/adc_align_pkg.sv
//------------------------------------------------------------------------------
// adc_align_pkg : shared types and constants for the ADC lane aligner
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package adc_align_pkg;

  typedef enum logic [5:0] {
    ST_STARTUP = 6'b000001,
    ST_CHECK   = 6'b000010,
    ST_SLIP    = 6'b000100,
    ST_SETTLE  = 6'b001000,
    ST_NEXT    = 6'b010000,
    ST_DONE    = 6'b100000
  } state_t;

  localparam logic [7:0] DEFAULT_PATTERN = 8'hF0;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/align_lane_mux.sv
//------------------------------------------------------------------------------
// align_lane_mux : combinational selector of one lane word by lane index
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module align_lane_mux #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_LANES*DATA_W-1:0] lane_data,
  input  logic [IDX_W-1:0]            lane_idx,
  output logic [DATA_W-1:0]           word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_idx == IDX_W'(i)) begin
        word = lane_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/adc_align_ctrl.sv
//------------------------------------------------------------------------------
// adc_align_ctrl : per-lane bitslip training controller for deserialized ADC data
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module adc_align_ctrl
  import adc_align_pkg::*;
#(
  parameter int                NUM_LANES      = 4,
  parameter int                DATA_W         = 8,
  parameter logic [DATA_W-1:0] PATTERN        = DATA_W'(DEFAULT_PATTERN),
  parameter int                STARTUP_CYCLES = 8,
  parameter int                SETTLE_CYCLES  = 8
) (
  input  logic                        CLKDIV,
  input  logic                        rst_n,
  input  logic                        ce,
  input  logic                        start,
  input  logic [NUM_LANES*DATA_W-1:0] lane_data,
  output logic [NUM_LANES-1:0]        bslip,
  output logic [NUM_LANES-1:0]        lane_ok,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam int IDX_W   = clog2_min1(NUM_LANES);
  localparam int SLIP_W  = clog2_min1(DATA_W + 1);
  localparam int CNT_MAX = (STARTUP_CYCLES > SETTLE_CYCLES) ? STARTUP_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = clog2_min1(CNT_MAX);

  state_t                state, state_n;
  logic [IDX_W-1:0]      lane_idx, lane_idx_n;
  logic [SLIP_W-1:0]     slip_cnt, slip_cnt_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [NUM_LANES-1:0]  lane_ok_n;
  logic                  failed, failed_n;
  logic [DATA_W-1:0]     sel_word;
  logic [NUM_LANES-1:0]  lane_bit;

  align_lane_mux #(
    .NUM_LANES (NUM_LANES),
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W)
  ) u_mux (
    .lane_data (lane_data),
    .lane_idx  (lane_idx),
    .word      (sel_word)
  );

  assign lane_bit = NUM_LANES'(1) << lane_idx;

  always_ff @(posedge CLKDIV or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_STARTUP;
      lane_idx <= '0;
      slip_cnt <= '0;
      cnt      <= '0;
      lane_ok  <= '0;
      failed   <= 1'b0;
    end else begin
      state    <= state_n;
      lane_idx <= lane_idx_n;
      slip_cnt <= slip_cnt_n;
      cnt      <= cnt_n;
      lane_ok  <= lane_ok_n;
      failed   <= failed_n;
    end
  end

  always_comb begin
    state_n    = state;
    lane_idx_n = lane_idx;
    slip_cnt_n = slip_cnt;
    cnt_n      = cnt;
    lane_ok_n  = lane_ok;
    failed_n   = failed;
    bslip      = '0;

    // A realign request outside STARTUP overrides whatever the state would do.
    if (start && (state != ST_STARTUP)) begin
      state_n    = ST_STARTUP;
      lane_idx_n = '0;
      slip_cnt_n = '0;
      cnt_n      = '0;
      lane_ok_n  = '0;
      failed_n   = 1'b0;
    end else begin
      case (state)
        ST_STARTUP: begin
          if (ce) begin
            if (cnt == CNT_W'(STARTUP_CYCLES - 1)) begin
              state_n    = ST_CHECK;
              lane_idx_n = '0;
              slip_cnt_n = '0;
              cnt_n      = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (sel_word == PATTERN) begin
            lane_ok_n = lane_ok | lane_bit;
            state_n   = ST_NEXT;
          end else if (slip_cnt < SLIP_W'(DATA_W)) begin
            state_n = ST_SLIP;
          end else begin
            failed_n = 1'b1;
            state_n  = ST_NEXT;
          end
        end
        ST_SLIP: begin
          bslip      = lane_bit;
          slip_cnt_n = slip_cnt + 1'b1;
          cnt_n      = '0;
          state_n    = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt_n   = '0;
            state_n = ST_CHECK;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_NEXT: begin
          if (lane_idx == IDX_W'(NUM_LANES - 1)) begin
            state_n = ST_DONE;
          end else begin
            lane_idx_n = lane_idx + 1'b1;
            slip_cnt_n = '0;
            state_n    = ST_CHECK;
          end
        end
        ST_DONE: begin
          state_n = ST_DONE;
        end
        default: begin
          state_n    = ST_STARTUP;
          lane_idx_n = '0;
          slip_cnt_n = '0;
          cnt_n      = '0;
          lane_ok_n  = '0;
          failed_n   = 1'b0;
        end
      endcase
    end
  end

  assign busy  = (state != ST_DONE);
  assign done  = (state == ST_DONE);
  assign error = failed & done;

endmodule

`default_nettype wire
